// File: rtl/svm_feature_packer_pkg.sv
// -----------------------------------------------------------------------------
// svm_feature_packer_pkg
// Shared defaults, state types and helpers for the SVM feature packer.
//   DEF_*        : default parameter values for the packer and quantizer
//   ceil_log2    : elaboration-time helper for index counter widths
//   asm_state_e  : assembly FSM states
//   out_state_e  : output register occupancy states
// -----------------------------------------------------------------------------
package svm_feature_packer_pkg;

    localparam int DEF_NBITS     = 5;
    localparam int DEF_F_WIDTH   = 4;
    localparam int DEF_RAW_WIDTH = 16;
    localparam int DEF_SHIFT     = 11;

    // Constant-only use: sizes the feature index counter at elaboration.
    // Never returns less than 1 so the counter always has at least one bit.
    function automatic int ceil_log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    typedef enum logic {
        ASM_FILL = 1'b0,
        ASM_HOLD = 1'b1
    } asm_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/svm_feature_packer_quant.sv
// -----------------------------------------------------------------------------
// svm_feature_quant
// Combinational quantizer: floor arithmetic shift of a signed raw feature,
// then saturation to a signed NBITS result.
//   raw_feature : signed raw feature, RAW_WIDTH bits
//   q_feature   : quantized two's-complement feature, NBITS bits
//   q_sat       : high when the shifted value was clamped
// -----------------------------------------------------------------------------
module svm_feature_quant
    import svm_feature_packer_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int RAW_WIDTH = DEF_RAW_WIDTH,
    parameter int SHIFT     = DEF_SHIFT
) (
    input  logic signed [RAW_WIDTH-1:0] raw_feature,
    output logic        [NBITS-1:0]     q_feature,
    output logic                        q_sat
);

    localparam logic signed [31:0] Q_MAX = 32'sd2 ** (NBITS - 1) - 32'sd1;
    localparam logic signed [31:0] Q_MIN = -(32'sd2 ** (NBITS - 1));

    logic signed [RAW_WIDTH-1:0] shifted;
    logic signed [31:0]          shifted_ext;

    // >>> on a signed operand rounds toward negative infinity.
    assign shifted     = raw_feature >>> SHIFT;
    assign shifted_ext = 32'(shifted);

    always_comb begin
        q_feature = shifted_ext[NBITS-1:0];
        q_sat     = 1'b0;
        if (shifted_ext > Q_MAX) begin
            q_feature = Q_MAX[NBITS-1:0];
            q_sat     = 1'b1;
        end else if (shifted_ext < Q_MIN) begin
            q_feature = Q_MIN[NBITS-1:0];
            q_sat     = 1'b1;
        end
    end

endmodule

// File: rtl/svm_feature_packer.sv
// -----------------------------------------------------------------------------
// svm_feature_packer
// Quantizes a stream of signed raw features and packs F_WIDTH of them into
// one vector for the SVM classifier. An assembly register fills while the
// output register holds a finished vector, so one extra frame can be absorbed
// while the SVM stalls.
//   clk, rst      : clock, asynchronous active-high reset
//   raw_feature   : signed raw feature
//   raw_valid     : raw feature valid
//   raw_last      : marks the final feature of a frame
//   raw_ready     : packer can accept (depends on state only)
//   out_features  : packed vector, feature 0 in the low NBITS bits
//   fout_valid    : vector valid toward the SVM
//   fout_ready    : SVM accepts the vector
//   out_sat       : some feature of the presented vector saturated
//   frame_err     : one-cycle pulse after a misaligned raw_last
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ASM_FILL   | accepting features into the assembly register
// ASM_HOLD   | assembly register full, waiting for the output register
// OUT_EMPTY  | no vector presented
// OUT_VALID  | vector presented, held stable until released
// -----------------------------------------------------------------------------
module svm_feature_packer
    import svm_feature_packer_pkg::*;
#(
    parameter int NBITS       = DEF_NBITS,
    parameter int F_WIDTH     = DEF_F_WIDTH,
    parameter int LOG_F_WIDTH = ceil_log2(F_WIDTH),
    parameter int RAW_WIDTH   = DEF_RAW_WIDTH,
    parameter int SHIFT       = DEF_SHIFT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [RAW_WIDTH-1:0]  raw_feature,
    input  logic                         raw_valid,
    input  logic                         raw_last,
    output logic                         raw_ready,
    output logic [NBITS*F_WIDTH-1:0]     out_features,
    output logic                         fout_valid,
    input  logic                         fout_ready,
    output logic                         out_sat,
    output logic                         frame_err
);

    localparam int                     VEC_W    = NBITS * F_WIDTH;
    localparam logic [LOG_F_WIDTH-1:0] LAST_IDX = LOG_F_WIDTH'(F_WIDTH - 1);

    asm_state_e               asm_state_q, asm_state_d;
    out_state_e               out_state_q, out_state_d;
    logic [LOG_F_WIDTH-1:0]   fidx_q, fidx_d;
    logic [VEC_W-1:0]         asm_vec_q, asm_vec_d;
    logic                     asm_sat_q, asm_sat_d;
    logic [VEC_W-1:0]         out_vec_q, out_vec_d;
    logic                     out_sat_q, out_sat_d;
    logic                     frame_err_q, frame_err_d;

    logic [NBITS-1:0]         q_feature;
    logic                     q_sat;
    logic                     accept;
    logic                     release_out;
    logic                     out_free;
    logic                     at_last;
    logic [VEC_W-1:0]         cur_vec;
    logic                     cur_sat;
    logic                     load_out;
    logic [VEC_W-1:0]         load_vec;
    logic                     load_sat;

    svm_feature_quant #(
        .NBITS     (NBITS),
        .RAW_WIDTH (RAW_WIDTH),
        .SHIFT     (SHIFT)
    ) u_quant (
        .raw_feature (raw_feature),
        .q_feature   (q_feature),
        .q_sat       (q_sat)
    );

    assign raw_ready    = (asm_state_q == ASM_FILL);
    assign fout_valid   = (out_state_q == OUT_VALID);
    assign out_features = out_vec_q;
    assign out_sat      = out_sat_q;
    assign frame_err    = frame_err_q;

    assign accept      = raw_valid && raw_ready;
    assign release_out = fout_valid && fout_ready;
    assign out_free    = (out_state_q == OUT_EMPTY) || release_out;
    assign at_last     = (fidx_q == LAST_IDX);

    // Assembly contents with the current feature already written, so a frame
    // completing this cycle can go straight to the output register.
    always_comb begin
        cur_vec = asm_vec_q;
        for (int i = 0; i < F_WIDTH; i++) begin
            if (fidx_q == LOG_F_WIDTH'(i)) begin
                cur_vec[i*NBITS +: NBITS] = q_feature;
            end
        end
        cur_sat = asm_sat_q | q_sat;
    end

    always_comb begin
        asm_state_d = asm_state_q;
        fidx_d      = fidx_q;
        asm_vec_d   = asm_vec_q;
        asm_sat_d   = asm_sat_q;
        frame_err_d = 1'b0;
        load_out    = 1'b0;
        load_vec    = cur_vec;
        load_sat    = cur_sat;

        case (asm_state_q)
            ASM_FILL: begin
                if (accept) begin
                    if (at_last && raw_last) begin
                        fidx_d    = '0;
                        asm_sat_d = 1'b0;
                        if (out_free) begin
                            load_out = 1'b1;
                        end else begin
                            asm_vec_d   = cur_vec;
                            asm_sat_d   = cur_sat;
                            asm_state_d = ASM_HOLD;
                        end
                    end else if (at_last || raw_last) begin
                        // Misaligned frame: drop what was gathered so far.
                        fidx_d      = '0;
                        asm_sat_d   = 1'b0;
                        frame_err_d = 1'b1;
                    end else begin
                        asm_vec_d = cur_vec;
                        asm_sat_d = cur_sat;
                        fidx_d    = fidx_q + LOG_F_WIDTH'(1);
                    end
                end
            end
            ASM_HOLD: begin
                if (out_free) begin
                    load_out    = 1'b1;
                    load_vec    = asm_vec_q;
                    load_sat    = asm_sat_q;
                    asm_sat_d   = 1'b0;
                    asm_state_d = ASM_FILL;
                end
            end
            default: begin
                asm_state_d = ASM_FILL;
            end
        endcase
    end

    // A load on the release cycle keeps the register VALID with new contents.
    always_comb begin
        out_state_d = out_state_q;
        out_vec_d   = out_vec_q;
        out_sat_d   = out_sat_q;
        if (load_out) begin
            out_state_d = OUT_VALID;
            out_vec_d   = load_vec;
            out_sat_d   = load_sat;
        end else if (release_out) begin
            out_state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_q <= ASM_FILL;
            out_state_q <= OUT_EMPTY;
            fidx_q      <= '0;
            asm_vec_q   <= '0;
            asm_sat_q   <= 1'b0;
            out_vec_q   <= '0;
            out_sat_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            asm_state_q <= asm_state_d;
            out_state_q <= out_state_d;
            fidx_q      <= fidx_d;
            asm_vec_q   <= asm_vec_d;
            asm_sat_q   <= asm_sat_d;
            out_vec_q   <= out_vec_d;
            out_sat_q   <= out_sat_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_svm_feature_packer.sv
// -----------------------------------------------------------------------------
// tb_svm_feature_packer
// Directed bench for svm_feature_packer with NBITS=5, F_WIDTH=4,
// RAW_WIDTH=12, SHIFT=4. Inputs change 1 ns after the rising edge and
// outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_svm_feature_packer;

    localparam int NBITS     = 5;
    localparam int F_WIDTH   = 4;
    localparam int RAW_WIDTH = 12;
    localparam int SHIFT     = 4;
    localparam int VEC_W     = NBITS * F_WIDTH;

    logic                        clk;
    logic                        rst;
    logic signed [RAW_WIDTH-1:0] raw_feature;
    logic                        raw_valid;
    logic                        raw_last;
    logic                        raw_ready;
    logic [VEC_W-1:0]            out_features;
    logic                        fout_valid;
    logic                        fout_ready;
    logic                        out_sat;
    logic                        frame_err;

    int total = 0;
    int bad   = 0;

    svm_feature_packer #(
        .NBITS       (NBITS),
        .F_WIDTH     (F_WIDTH),
        .LOG_F_WIDTH (2),
        .RAW_WIDTH   (RAW_WIDTH),
        .SHIFT       (SHIFT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_feature  (raw_feature),
        .raw_valid    (raw_valid),
        .raw_last     (raw_last),
        .raw_ready    (raw_ready),
        .out_features (out_features),
        .fout_valid   (fout_valid),
        .fout_ready   (fout_ready),
        .out_sat      (out_sat),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference quantizer: floor shift by 4, clamp to [-16, 15].
    function automatic int qm(input int raw);
        int s;
        s = raw >>> SHIFT;
        if (s > 15) return 15;
        if (s < -16) return -16;
        return s;
    endfunction

    function automatic bit satm(input int raw);
        int s;
        s = raw >>> SHIFT;
        return (s > 15) || (s < -16);
    endfunction

    function automatic logic [VEC_W-1:0] pk(input int r0, input int r1, input int r2, input int r3);
        return {5'(qm(r3)), 5'(qm(r2)), 5'(qm(r1)), 5'(qm(r0))};
    endfunction

    function automatic logic pks(input int r0, input int r1, input int r2, input int r3);
        return satm(r0) | satm(r1) | satm(r2) | satm(r3);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int raw, input bit last);
        raw_valid   = 1'b1;
        raw_feature = RAW_WIDTH'(raw);
        raw_last    = last;
        tick(1);
    endtask

    task automatic idle();
        raw_valid = 1'b0;
        raw_last  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  raw_ready,    1);
        chk({tag, "_vld"},  fout_valid,   0);
        chk({tag, "_data"}, out_features, 0);
        chk({tag, "_sat"},  out_sat,      0);
        chk({tag, "_ferr"}, frame_err,    0);
    endtask

    int               strm [3][4];
    logic [VEC_W-1:0] exp1;
    logic [VEC_W-1:0] vec_a;
    logic [VEC_W-1:0] vec_b;

    initial begin
        strm = '{'{16, 32, 48, 64}, '{-16, -32, 300, -300}, '{100, -100, 240, -256}};
        rst         = 1'b1;
        raw_valid   = 1'b0;
        raw_last    = 1'b0;
        raw_feature = '0;
        fout_ready  = 1'b1;
        #2;
        chk_reset_vals("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);

        // Quantization corners: in range, clamp high, clamp low, -1 floors to -1
        exp1 = {5'h1F, 5'h10, 5'h0F, 5'h05};
        send(80, 0);
        send(2047, 0);
        send(-2048, 0);
        chk("q_pre_vld", fout_valid, 0);
        send(-1, 1);
        idle();
        chk("q_vld", fout_valid, 1);
        chk("q_data", out_features, exp1);
        chk("q_sat", out_sat, 1);
        tick(1);
        chk("q_released", fout_valid, 0);

        // Back-to-back frames with a ready sink
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < 4; i++) begin
                send(strm[fr][i], i == 3);
                chk("strm_rdy", raw_ready, 1);
                if (i == 0 && fr > 0) chk("strm_gap", fout_valid, 0);
                if (i == 3) begin
                    chk("strm_vld", fout_valid, 1);
                    chk("strm_data", out_features, pk(strm[fr][0], strm[fr][1], strm[fr][2], strm[fr][3]));
                    chk("strm_sat", out_sat, pks(strm[fr][0], strm[fr][1], strm[fr][2], strm[fr][3]));
                end
            end
        end
        idle();
        tick(1);

        // Back-pressure: frame A held, frame B absorbed, then both drain
        vec_a = pk(80, 96, 112, 128);
        vec_b = pk(-16, 400, 0, -1);
        fout_ready = 1'b0;
        send(80, 0);
        send(96, 0);
        send(112, 0);
        send(128, 1);
        chk("bp_a_vld", fout_valid, 1);
        chk("bp_a_data", out_features, vec_a);
        send(-16, 0);
        send(400, 0);
        send(0, 0);
        chk("bp_a_stable", out_features, vec_a);
        chk("bp_rdy_fill", raw_ready, 1);
        send(-1, 1);
        idle();
        chk("bp_rdy_hold", raw_ready, 0);
        chk("bp_a_still", out_features, vec_a);
        tick(12);
        chk("bp_a_long", out_features, vec_a);
        chk("bp_a_sat", out_sat, 0);
        chk("bp_rdy_long", raw_ready, 0);
        fout_ready = 1'b1;
        tick(1);
        chk("bp_b_vld", fout_valid, 1);
        chk("bp_b_data", out_features, vec_b);
        chk("bp_b_sat", out_sat, 1);
        chk("bp_rdy_back", raw_ready, 1);
        tick(1);
        chk("bp_drained", fout_valid, 0);

        // Early raw_last at index 1, saturated feature must not leak forward
        send(80, 0);
        send(2047, 1);
        idle();
        chk("early_ferr", frame_err, 1);
        chk("early_novld", fout_valid, 0);
        tick(1);
        chk("early_ferr_off", frame_err, 0);
        send(32, 0);
        send(48, 0);
        send(64, 0);
        send(80, 1);
        idle();
        chk("early_next_vld", fout_valid, 1);
        chk("early_next_data", out_features, pk(32, 48, 64, 80));
        chk("early_next_sat", out_sat, 0);
        tick(1);

        // Missing raw_last at index 3
        send(2047, 0);
        send(16, 0);
        send(16, 0);
        send(16, 0);
        idle();
        chk("miss_ferr", frame_err, 1);
        chk("miss_novld", fout_valid, 0);
        tick(1);
        chk("miss_ferr_off", frame_err, 0);
        send(-48, 0);
        send(-64, 0);
        send(-80, 0);
        send(-96, 1);
        idle();
        chk("miss_next_vld", fout_valid, 1);
        chk("miss_next_data", out_features, pk(-48, -64, -80, -96));
        chk("miss_next_sat", out_sat, 0);
        tick(1);

        // Asynchronous reset mid-frame
        send(16, 0);
        send(32, 0);
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset while a vector is presented
        fout_ready = 1'b0;
        send(16, 0);
        send(16, 0);
        send(16, 0);
        send(16, 1);
        idle();
        chk("rst_vld_pre", fout_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_vld");
        rst = 1'b0;
        @(posedge clk);
        #1;
        fout_ready = 1'b1;
        send(-48, 0);
        send(16, 0);
        send(0, 0);
        send(2047, 1);
        idle();
        chk("post_rst_vld", fout_valid, 1);
        chk("post_rst_data", out_features, pk(-48, 16, 0, 2047));
        chk("post_rst_sat", out_sat, 1);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
